// File: rtl/mem_arbiter_pkg.sv
// Shared types and helpers for the byte-serialising IF/MEM RAM arbiter.
package mem_arbiter_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 3;

  localparam logic [1:0] BYTE = 2'd0;
  localparam logic [1:0] HALF = 2'd1;
  localparam logic [1:0] WORD = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_e;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_e;

  // Bytes moved on the RAM port for a given width code; code 3 behaves as a word.
  function automatic logic [CNT_W-1:0] byte_count(input logic [1:0] width);
    case (width)
      BYTE:    return CNT_W'(1);
      HALF:    return CNT_W'(2);
      default: return CNT_W'(4);
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates IF fetches and MEM loads/stores onto one byte-wide RAM port.
// Optional macro MEM_ARB_ROUND_ROBIN_EN lets IF win a tie right after a MEM grant.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_cancel,
  output logic              if_done,
  output logic [DATA_W-1:0] if_data,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_width,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_done,
  output logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] ram_a,
  output logic [7:0]        ram_dout,
  output logic              ram_wr,
  input  logic [7:0]        ram_din
);

  state_e            state;
  owner_e            owner;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  n_bytes;
  logic [DATA_W-1:0] asm_q;
  logic [DATA_W-1:0] asm_cap;
  logic [1:0]        cap_idx;
  logic              if_ok;
  logic              grant_mem;
  logic              grant_if;
  logic              cancel_if;
  logic              last_cap;

  assign if_ok     = if_req && !if_cancel;
  assign cancel_if = (owner == OWN_IF) && if_cancel;
  assign last_cap  = (cnt == n_bytes);
  assign cap_idx   = 2'(cnt - CNT_W'(1));

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_was_mem;
  assign grant_mem = mem_req && !(if_ok && last_was_mem);
`else
  assign grant_mem = mem_req;
`endif
  assign grant_if = if_ok && !grant_mem;

  // ram_din always belongs to the address issued one cycle earlier.
  always_comb begin
    asm_cap = asm_q;
    asm_cap[{cap_idx, 3'b000} +: 8] = ram_din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= OWN_IF;
      cnt       <= '0;
      n_bytes   <= '0;
      asm_q     <= '0;
      if_done   <= 1'b0;
      if_data   <= '0;
      mem_done  <= 1'b0;
      mem_rdata <= '0;
      ram_a     <= '0;
      ram_dout  <= '0;
      ram_wr    <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_was_mem <= 1'b0;
`endif
    end else begin
      if_done  <= 1'b0;
      mem_done <= 1'b0;
      ram_wr   <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_mem) begin
            owner   <= OWN_MEM;
            n_bytes <= byte_count(mem_width);
            cnt     <= '0;
            ram_a   <= mem_addr;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_was_mem <= 1'b1;
`endif
            if (mem_we) begin
              state    <= WR;
              ram_wr   <= 1'b1;
              ram_dout <= mem_wdata[7:0];
              asm_q    <= mem_wdata;
            end else begin
              state <= RD;
              asm_q <= '0;
            end
          end else if (grant_if) begin
            owner   <= OWN_IF;
            n_bytes <= CNT_W'(4);
            cnt     <= '0;
            ram_a   <= if_addr;
            asm_q   <= '0;
            state   <= RD;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_was_mem <= 1'b0;
`endif
          end
        end
        RD: begin
          if (cancel_if) begin
            state <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (cnt != '0) asm_q <= asm_cap;
            if ((cnt + CNT_W'(1)) < n_bytes) ram_a <= ram_a + ADDR_W'(1);
            if (last_cap) begin
              state <= DONE;
              if (owner == OWN_MEM) begin
                mem_done  <= 1'b1;
                mem_rdata <= asm_cap;
              end else begin
                if_done <= 1'b1;
                if_data <= asm_cap;
              end
            end
          end
        end
        WR: begin
          // asm_q holds the store data shifted so its low byte is the one on the bus.
          if (cnt == (n_bytes - CNT_W'(1))) begin
            state    <= DONE;
            mem_done <= 1'b1;
          end else begin
            ram_wr   <= 1'b1;
            cnt      <= cnt + CNT_W'(1);
            ram_a    <= ram_a + ADDR_W'(1);
            ram_dout <= asm_q[15:8];
            asm_q    <= asm_q >> 8;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// against a transaction-level memory model.
module tb_mem_arbiter;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_cancel;
  logic        if_done;
  logic [31:0] if_data;
  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_width;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_done;
  logic [31:0] mem_rdata;
  logic [31:0] ram_a;
  logic [7:0]  ram_dout;
  logic        ram_wr;
  logic [7:0]  ram_din;

  mem_arbiter #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_cancel(if_cancel),
    .if_done(if_done), .if_data(if_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_width(mem_width),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_done(mem_done), .mem_rdata(mem_rdata),
    .ram_a(ram_a), .ram_dout(ram_dout), .ram_wr(ram_wr), .ram_din(ram_din)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit [7:0]    ram     [bit [31:0]];
  bit [7:0]    ref_mem [bit [31:0]];
  logic [31:0] a_q[$];
  logic [39:0] wr_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  bit          last_mem = 1'b0;

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : 8'h00;
  endfunction

  // Synchronous byte RAM: read data appears the cycle after the address.
  initial begin
    ram_din = 8'h00;
    forever begin
      @(posedge clk);
      ram_din <= ram_rd(ram_a);
      if (ram_wr) ram[ram_a] = ram_dout;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      a_q.push_back(ram_a);
      if (ram_wr) wr_q.push_back({ram_dout, ram_a});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic poke(input logic [31:0] a, input logic [7:0] v);
    ram[a] = v;
    ref_mem[a] = v;
  endtask

  function automatic int nbytes(input logic [1:0] w);
    return (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] exp_read(input logic [31:0] a, input int n);
    logic [31:0] r = '0;
    for (int k = 0; k < n; k++) begin
      logic [31:0] ak = a + 32'(k);
      logic [7:0]  b  = ref_mem.exists(ak) ? ref_mem[ak] : 8'h00;
      r = r | (32'(b) << (8 * k));
    end
    return r;
  endfunction

  task automatic ref_store(input logic [31:0] a, input int n, input logic [31:0] wd);
    for (int k = 0; k < n; k++) ref_mem[a + 32'(k)] = wd[8*k +: 8];
  endtask

  task automatic check_writes(input string tag, input logic [31:0] a, input int n,
                              input logic [31:0] wd);
    check({tag, "_nwr"}, 32'(wr_q.size()), 32'(n));
    for (int k = 0; k < n && k < wr_q.size(); k++) begin
      check({tag, "_wa"}, wr_q[k][31:0], a + 32'(k));
      check({tag, "_wd"}, 32'(wr_q[k][39:32]), 32'(wd[8*k +: 8]));
    end
  endtask

  task automatic do_if(input logic [31:0] a, output logic [31:0] d, output int dc);
    bit seen;
    seen = 1'b0;
    d = '0;
    dc = -1;
    if_addr = a;
    if_req = 1'b1;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (if_done) begin
        seen = 1'b1;
        dc = cyc;
        d = if_data;
      end
    end
    if_req = 1'b0;
    check("if_done_seen", 32'(seen), 32'd1);
  endtask

  task automatic do_mem(input logic we, input logic [1:0] w, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd, output int dc);
    bit seen;
    seen = 1'b0;
    rd = '0;
    dc = -1;
    mem_we = we;
    mem_width = w;
    mem_addr = a;
    mem_wdata = wd;
    mem_req = 1'b1;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (mem_done) begin
        seen = 1'b1;
        dc = cyc;
        rd = mem_rdata;
      end
    end
    mem_req = 1'b0;
    check("mem_done_seen", 32'(seen), 32'd1);
  endtask

  // One idle cycle after each transaction; done pulses must be over by then.
  task automatic gap();
    @(negedge clk);
    check("done_low", 32'({if_done, mem_done}), 32'd0);
  endtask

  initial begin
    logic [31:0] d, md, w;
    int start, dc, mdc, m2dc, seen;

    rst = 1'b1; if_req = 1'b0; if_addr = '0; if_cancel = 1'b0;
    mem_req = 1'b0; mem_we = 1'b0; mem_width = 2'd0; mem_addr = '0; mem_wdata = '0;

    poke(32'h100, 8'h13); poke(32'h101, 8'h05); poke(32'h102, 8'h10); poke(32'h103, 8'h00);
    poke(32'h200, 8'hEF); poke(32'h201, 8'hBE); poke(32'h202, 8'hAD); poke(32'h203, 8'hDE);
    poke(32'h301, 8'h11); poke(32'h302, 8'h22); poke(32'h303, 8'h5A);
    poke(32'h7FF, 8'h80);
    for (int i = 0; i < 4; i++)   poke(32'h40 + 32'(i), 8'($urandom));
    for (int i = 0; i < 256; i++) poke(32'h1000 + 32'(i), 8'($urandom));
    for (int i = 0; i < 72; i++)  poke(32'h2000 + 32'(i), 8'($urandom));
    for (int i = 0; i < 16; i++)  poke(32'hFFFFFFF8 + 32'(i), 8'($urandom));

    repeat (3) @(negedge clk);
    check("rst_if_done", 32'(if_done), 32'd0);
    check("rst_mem_done", 32'(mem_done), 32'd0);
    check("rst_ram_wr", 32'(ram_wr), 32'd0);
    check("rst_ram_a", ram_a, 32'd0);
    check("rst_ram_dout", 32'(ram_dout), 32'd0);
    check("rst_if_data", if_data, 32'd0);
    check("rst_mem_rdata", mem_rdata, 32'd0);
    rst = 1'b0;
    gap();

    // IF word fetch
    a_q.delete();
    start = cyc;
    do_if(32'h100, d, dc);
    check("fetch_lat", 32'(dc - start), 32'd6);
    check("fetch_data", d, 32'h00100513);
    for (int k = 0; k < 4; k++) check("fetch_ram_a", a_q[k], 32'h100 + 32'(k));
    last_mem = 1'b0;
    gap();
    check("fetch_data_held", if_data, 32'h00100513);

    // Simultaneous lw and fetch: MEM first, IF granted in the IDLE after DONE
    start = cyc;
    fork
      do_mem(1'b0, 2'd2, 32'h200, 32'h0, md, mdc);
      do_if(32'h100, d, dc);
    join
    check("tie_mem_lat", 32'(mdc - start), 32'd6);
    check("tie_mem_data", md, 32'hDEADBEEF);
    check("tie_if_after", 32'(dc - mdc), 32'd7);
    check("tie_if_data", d, 32'h00100513);
    last_mem = 1'b0;
    gap();

    // sh at 0x301
    wr_q.delete();
    start = cyc;
    do_mem(1'b1, 2'd1, 32'h301, 32'h1234ABCD, md, mdc);
    check("sh_lat", 32'(mdc - start), 32'd3);
    check_writes("sh", 32'h301, 2, 32'h1234ABCD);
    check("sh_303_kept", 32'(ram_rd(32'h303)), 32'h5A);
    ref_store(32'h301, 2, 32'h1234ABCD);
    last_mem = 1'b1;
    gap();

    // lb at 0x7FF
    a_q.delete();
    start = cyc;
    do_mem(1'b0, 2'd0, 32'h7FF, 32'h0, md, mdc);
    check("lb_lat", 32'(mdc - start), 32'd3);
    check("lb_data", md, 32'h00000080);
    check("lb_ram_a0", a_q[0], 32'h7FF);
    check("lb_ram_a1", a_q[1], 32'h7FF);
    last_mem = 1'b1;
    gap();

    // if_cancel right after an IF grant
    if_addr = 32'h180; if_req = 1'b1;
    @(negedge clk);
    if_cancel = 1'b1; if_req = 1'b0;
    @(negedge clk);
    if_cancel = 1'b0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (if_done) seen++;
    end
    check("cancel_no_done", 32'(seen), 32'd0);
    check("cancel_data_kept", if_data, 32'h00100513);
    last_mem = 1'b0;
    start = cyc;
    do_if(32'h40, d, dc);
    check("after_cancel_lat", 32'(dc - start), 32'd6);
    check("after_cancel_data", d, exp_read(32'h40, 4));
    gap();

    // rst during the 3rd byte of sw
    w = $urandom;
    wr_q.delete();
    mem_we = 1'b1; mem_width = 2'd2; mem_addr = 32'h500; mem_wdata = w; mem_req = 1'b1;
    repeat (3) @(negedge clk);
    check("sw3_ram_wr", 32'(ram_wr), 32'd1);
    check("sw3_ram_a", ram_a, 32'h502);
    check("sw3_ram_dout", 32'(ram_dout), 32'(w[23:16]));
    rst = 1'b1; mem_req = 1'b0;
    @(negedge clk);
    check("rstmid_ram_wr", 32'(ram_wr), 32'd0);
    check("rstmid_done", 32'({if_done, mem_done}), 32'd0);
    check("rstmid_ram_a", ram_a, 32'd0);
    check("rstmid_ram_dout", 32'(ram_dout), 32'd0);
    check("rstmid_data", if_data | mem_rdata, 32'd0);
    rst = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (mem_done) seen++;
    end
    check("rstmid_no_done", 32'(seen), 32'd0);
    ref_store(32'h500, 3, w);
    last_mem = 1'b0;

    // Two back-to-back stores with fetch pending
    wr_q.delete();
    start = cyc;
    fork
      begin
        do_mem(1'b1, 2'd2, 32'h2100, 32'hA1B2C3D4, md, mdc);
        do_mem(1'b1, 2'd1, 32'h2104, 32'h00005566, md, m2dc);
      end
      do_if(32'h1010, d, dc);
    join
    check("bb_mem1_lat", 32'(mdc - start), 32'd5);
    check("bb_mem2_done", 32'(m2dc - mdc), RR ? 32'd11 : 32'd4);
    check("bb_if_done", 32'(dc - mdc), RR ? 32'd7 : 32'd11);
    check("bb_if_data", d, exp_read(32'h1010, 4));
    check("bb_nwr", 32'(wr_q.size()), 32'd6);
    ref_store(32'h2100, 4, 32'hA1B2C3D4);
    ref_store(32'h2104, 2, 32'h00005566);
    last_mem = RR;
    gap();

    // Randomized traffic against the memory model
    for (int it = 0; it < 40; it++) begin
      int op, mlat;
      bit we, mem_first;
      logic [1:0]  wdt;
      logic [31:0] ia, ma, wd, exp_m, exp_i;
      op  = int'($urandom_range(0, 3));
      ia  = 32'h1000 + 32'($urandom_range(0, 200));
      ma  = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFC + 32'($urandom_range(0, 3))
                                        : 32'h2000 + 32'($urandom_range(0, 63));
      wdt = 2'($urandom_range(0, 3));
      we  = 1'($urandom_range(0, 1));
      wd  = $urandom;
      mlat  = we ? nbytes(wdt) + 1 : nbytes(wdt) + 2;
      exp_m = exp_read(ma, nbytes(wdt));
      exp_i = exp_read(ia, 4);
      wr_q.delete();
      start = cyc;
      if (op == 0) begin
        do_if(ia, d, dc);
        check("rnd_if_lat", 32'(dc - start), 32'd6);
        check("rnd_if_data", d, exp_i);
        last_mem = 1'b0;
      end else if (op == 3) begin
        mem_first = !(RR && last_mem);
        fork
          do_mem(we, wdt, ma, wd, md, mdc);
          do_if(ia, d, dc);
        join
        check("rnd_both_mem_lat", 32'(mdc - start), 32'(mem_first ? mlat : 7 + mlat));
        check("rnd_both_if_lat", 32'(dc - start), 32'(mem_first ? mlat + 7 : 6));
        check("rnd_both_if_data", d, exp_i);
        if (!we) check("rnd_both_mem_data", md, exp_m);
        else check_writes("rnd_both", ma, nbytes(wdt), wd);
        if (we) ref_store(ma, nbytes(wdt), wd);
        last_mem = !mem_first;
      end else begin
        do_mem(we, wdt, ma, wd, md, mdc);
        check("rnd_mem_lat", 32'(mdc - start), 32'(mlat));
        if (!we) check("rnd_mem_data", md, exp_m);
        else check_writes("rnd_st", ma, nbytes(wdt), wd);
        if (we) ref_store(ma, nbytes(wdt), wd);
        last_mem = 1'b1;
      end
      gap();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single byte-wide RAM port between instruction fetch (IF) and the load/store stage (MEM).
- Serialises each word, half or byte access into per-byte bus cycles and returns assembled little-endian data.
- The pipeline controller turns `req && !done` into stalls, alongside the decode stage's load-use stall.

Parameters:
- ADDR_W, 32, width of the byte address; address arithmetic wraps modulo 2^ADDR_W.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- if_req  in  1  IF wants a 4-byte read; held high until if_done.
- if_addr  in  ADDR_W  fetch address; stable while if_req is high.
- if_cancel  in  1  branch taken; abandon any pending or in-flight IF read.
- if_done  out  1  one-cycle pulse: if_data valid.
- if_data  out  32  fetched instruction.
- mem_req  in  1  MEM access request; held high until mem_done.
- mem_we  in  1  1 = store, 0 = load.
- mem_width  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as word.
- mem_addr  in  ADDR_W  access address; misalignment is allowed.
- mem_wdata  in  32  store data; low bytes are used first.
- mem_done  out  1  one-cycle pulse: access complete.
- mem_rdata  out  32  load data, zero-extended; the MEM stage sign-extends.
- ram_a  out  ADDR_W  RAM byte address (registered).
- ram_dout  out  8  RAM write byte (registered).
- ram_wr  out  1  RAM write strobe (registered).
- ram_din  in  8  RAM read byte; valid the cycle after ram_a.

Behaviour:
- Reset values: all outputs 0, state IDLE, byte counter 0, assembly register 0.
- States:
  - IDLE: no access in progress.
  - RD: issue byte addresses of a read.
  - WR: drive bytes of a write.
  - DONE: one cycle; pulses the owner's done.
- Byte count N: 1 for width 0, 2 for width 1, 4 for width 2/3; IF reads always use N = 4.
- Arbitration happens only in IDLE, at a clock edge.
  - MEM has priority over IF; IF wins only if mem_req = 0.
  - An IF request is not granted while if_cancel = 1.
- The transfer is non-preemptive; the winner's address, width and wdata are latched at grant.
- Read (grant edge ends cycle T):
  - Cycles T+1..T+N: ram_a = addr+k.
  - ram_din is captured into byte k at the end of cycle T+2+k.
  - The last capture is at the end of cycle T+N+1; DONE occupies cycle T+N+2.
  - Word read: done appears 6 cycles after the grant cycle.
- Write: cycles T+1..T+N drive ram_a = addr+k, ram_dout = wdata byte k, ram_wr = 1; DONE occupies cycle T+N+1.
- ram_wr is 1 only in WR; in all other states ram_wr = 0 and ram_a holds its last value.
- DONE:
  - The owner's done pulses high for exactly one cycle; the data output is held stable until the next done.
  - No grant is made in DONE, so a requester dropping req on the following edge is never re-accepted.
  - The next state is IDLE.
- Unused upper bytes of mem_rdata are 0.
- if_cancel during an IF RD or DONE: next state IDLE, no if_done pulse, captured data is discarded.
- if_cancel has no effect on a MEM transaction.
- rst mid-transaction: the next cycle has ram_wr = 0, no done, state IDLE. A partially written store is left as-is, which is acceptable.
- Address wrap: addr+k crossing 2^ADDR_W-1 wraps to 0.
- Requests dropped before done (other than via if_cancel) are protocol violations and are undefined.

Optional Feature:
- MEM_ARB_ROUND_ROBIN_EN: a register `last_was_mem` is set on each MEM grant and cleared on each IF grant.
  - With the macro: if both requests are pending in IDLE and last_was_mem = 1, IF wins. This prevents store bursts from starving fetch.
  - Without the macro: fixed MEM priority; the register is not built.

Decomposition:
- Shared package/defines include:
  - width codes (BYTE=2'd0, HALF=2'd1, WORD=2'd2);
  - state encodings (IDLE, RD, WR, DONE);
  - owner codes (OWN_IF, OWN_MEM).
- No sub-module: the byte sequencer is one FSM plus a 3-bit counter and a 32-bit assembly register. Splitting it would only add ports.

Test Plan:
- IF word fetch: RAM[0x100..0x103] = 13,05,10,00; if_req with if_addr = 0x100 → ram_a sequence 100,101,102,103; if_done 6 cycles after grant; if_data = 0x00100513.
- Simultaneous if_req and mem_req (lw at 0x200, RAM = 0xDEADBEEF) → mem_done first with mem_rdata = 0xDEADBEEF; IF is granted in the IDLE cycle after DONE.
- sh at 0x301 with wdata = 0x1234ABCD → two cycles with ram_wr = 1: (0x301, 0xCD), then (0x302, 0xAB); mem_done the next cycle; RAM[0x303] unchanged.
- lb at 0x7FF when RAM = 0x80 → mem_rdata = 0x00000080 (zero-extended); single address cycle.
- if_cancel asserted the cycle after an IF grant → IDLE next cycle, if_done never pulses; a new if_req at 0x40 then completes normally.
- rst during the 3rd byte of sw → ram_wr = 0 the next cycle, no mem_done, all outputs 0.
- With MEM_ARB_ROUND_ROBIN_EN, two back-to-back MEM stores with if_req held → order MEM, IF, MEM.
- Without MEM_ARB_ROUND_ROBIN_EN, the same stimulus → order MEM, MEM, IF.
